button_event_ctrl: RTL and testbench

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Debounced push-button event controller with a CPU-readable event FIFO.
//
// Each active-low key is synchronised, then debounced against a shared 1 ms tick.
// Debounced presses raise a per-key pending flag. A round-robin arbiter grants one
// pending key per cycle into a small event FIFO. The CPU reads the FIFO head at
// 411720, which pops once per access. It reads the status word at 411724, which
// clears the sticky overflow flag once per access.
//
// Optional feature macro: BUTTON_RELEASE_EVT_EN adds release events (bit 8 = 1).
//
// Ports:
//   clk      - system clock, rising edge
//   nrst     - asynchronous active-low reset
//   keys     - raw key levels, active-low, asynchronous
//   busaddr  - CPU bus address
//   busdata  - CPU read data (combinational)
module button_event_ctrl #(
    parameter int unsigned CLKRATE = 25000000,
    parameter int unsigned DBMSEC  = 20,
    parameter int unsigned NKEYS   = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NKEYS-1:0] keys,
    input  logic [31:0]      busaddr,
    output logic [31:0]      busdata
);

    localparam int unsigned TICKDIV = CLKRATE / 1000;
    localparam int unsigned TW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned KW      = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    localparam logic [31:0]   ADDR_FIFO = 32'd411720;
    localparam logic [31:0]   ADDR_STAT = 32'd411724;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKDIV - 1);
    localparam logic [7:0]    DB_LAST   = 8'(DBMSEC - 1);

    // 1 ms tick from a single free-running counter
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // Two-flop synchronisers, idle high (released)
    logic [NKEYS-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    // Debounce: flip after DBMSEC consecutive ticks that see a differing level
    logic [NKEYS-1:0] db, db_next, flip;
    logic [7:0]       ms_cnt  [NKEYS];
    logic [7:0]       ms_next [NKEYS];

    always_comb begin
        db_next = db;
        flip    = '0;
        for (int k = 0; k < NKEYS; k++) begin
            ms_next[k] = ms_cnt[k];
            if (tick) begin
                if (sync2[k] != db[k]) begin
                    if (ms_cnt[k] == DB_LAST) begin
                        db_next[k] = ~db[k];
                        flip[k]    = 1'b1;
                        ms_next[k] = '0;
                    end else begin
                        ms_next[k] = ms_cnt[k] + 8'd1;
                    end
                end else begin
                    ms_next[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            db <= '1;
            for (int k = 0; k < NKEYS; k++) ms_cnt[k] <= '0;
        end else begin
            db <= db_next;
            for (int k = 0; k < NKEYS; k++) ms_cnt[k] <= ms_next[k];
        end
    end

    // Pending flags and arbitration request vector
    logic [NKEYS-1:0] press_pend, rel_pend, req, gnt_oh;
    logic             gnt_valid, gnt_rel;
    logic [KW-1:0]    gnt_idx, last;

    assign req = press_pend | rel_pend;

    // Round robin: lowest requester strictly above last, else lowest overall (wrap)
    always_comb begin
        logic          hi_found;
        logic [KW-1:0] hi_idx, lo_idx;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        gnt_valid = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_valid = 1'b1;
                lo_idx    = KW'(k);
                if (KW'(k) > last) begin
                    hi_found = 1'b1;
                    hi_idx   = KW'(k);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        // A key with both flags set issues its press first
        gnt_rel = gnt_valid && !press_pend[gnt_idx];
        for (int k = 0; k < NKEYS; k++) gnt_oh[k] = gnt_valid && (gnt_idx == KW'(k));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            press_pend <= '0;
            last       <= KW'(NKEYS - 1);
        end else begin
            // A new edge in the grant cycle survives the clear
            press_pend <= (press_pend & ~(gnt_oh & {NKEYS{!gnt_rel}})) | (flip & db);
            if (gnt_valid) last <= gnt_idx;
        end
    end

`ifdef BUTTON_RELEASE_EVT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) rel_pend <= '0;
        else       rel_pend <= (rel_pend & ~(gnt_oh & {NKEYS{gnt_rel}})) | (flip & ~db);
    end
`else
    assign rel_pend = '0;
`endif

    // Event FIFO; entries hold {release, key index}
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push, drop;
    logic          in_fifo, in_stat, hit_fifo, hit_stat, ovf;

    assign hit_fifo = (busaddr == ADDR_FIFO);
    assign hit_stat = (busaddr == ADDR_STAT);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    // Only the first cycle of a matching address acts
    assign pop      = hit_fifo && !in_fifo && !empty;
    assign push     = gnt_valid && (!full || pop);
    assign drop     = gnt_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {gnt_rel, 8'(gnt_idx)};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            in_fifo <= 1'b0;
            in_stat <= 1'b0;
        end else begin
            in_fifo <= hit_fifo;
            in_stat <= hit_stat;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
            // Overflow set wins over a same-cycle clear
            if (drop)                     ovf <= 1'b1;
            else if (hit_stat && !in_stat) ovf <= 1'b0;
        end
    end

    // Read mux; status count field is 4 bits wide
    always_comb begin
        busdata = '0;
        if (hit_fifo) begin
            if (!empty) begin
                busdata[31]  = 1'b1;
                busdata[8:0] = mem[rd_ptr];
            end
        end else if (hit_stat) begin
            busdata[8]   = ovf;
            busdata[3:0] = 4'(count);
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: CLKRATE=1e6 (1000 cycles per ms), DBMSEC=3,
// NKEYS=4, DEPTH=4. Expected event words are queued when key stimulus is applied
// and popped when the bench reads the FIFO address.
module tb_button_event_ctrl;

    localparam int unsigned MS     = 1000;
    localparam int unsigned SETTLE = 3 * MS + 10;
    localparam logic [31:0] A_FIFO = 32'd411720;
    localparam logic [31:0] A_STAT = 32'd411724;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  keys = 4'hf;
    logic [31:0] busaddr = '0;
    logic [31:0] busdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    button_event_ctrl #(
        .CLKRATE(1000000),
        .DBMSEC (3),
        .NKEYS  (4),
        .DEPTH  (4)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .keys   (keys),
        .busaddr(busaddr),
        .busdata(busdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle bus access; the address is dropped before the following cycle
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        busaddr = a;
        #1 d = busdata;
        @(negedge clk);
        busaddr = '0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d, e;
        bus_read(A_FIFO, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        check(tag, d, e);
    endtask

    task automatic stat_check(input string tag, input logic [31:0] e);
        logic [31:0] d;
        bus_read(A_STAT, d);
        check(tag, d, e);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        cycles(3);
        nrst = 1'b1;
    endtask

    // Hold the status address until the count field equals want, bounded by budget
    task automatic wait_count(input logic [3:0] want, input int budget,
                              output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        @(negedge clk);
        busaddr = A_STAT;
        while (!found && waited < budget) begin
            #1;
            if (busdata[3:0] == want) found = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        @(negedge clk);
        busaddr = '0;
    endtask

    initial begin
        int          w;
        bit          found;
        logic [31:0] d;

        // Reset state
        #2 busaddr = A_FIFO;
        #1 check("reset_fifo_word", busdata, 32'h0);
        busaddr = A_STAT;
        #1 check("reset_status", busdata, 32'h0);
        busaddr = '0;
        cycles(3);
        nrst = 1'b1;
        stat_check("post_reset_status", 32'h0);

        // Single press of key 1, held 5 ms
        @(negedge clk);
        keys[1] = 1'b0;
        exp_q.push_back(32'h8000_0001);
        wait_count(4'd1, 4 * MS, w, found);
        check("press_within_4ms", 32'(found), 32'd1);
        check("press_latency_gt_2ms", 32'(w > 2 * MS), 32'd1);
        cycles(5 * MS - w);
        keys[1] = 1'b1;
`ifdef BUTTON_RELEASE_EVT_EN
        exp_q.push_back(32'h8000_0101);
        cycles(SETTLE);
        stat_check("single_count", 32'h2);
`else
        cycles(SETTLE);
        stat_check("single_count", 32'h1);
`endif
        pop_check("single_event");
        pop_check("single_second_read");
        pop_check("single_empty_read");

        // Key 2 bouncing every 0.5 ms, phased so every sample sees it released
        do_reset();
        cycles(100);
        for (int i = 0; i < 10; i++) begin
            keys[2] = 1'b0;
            cycles(500);
            keys[2] = 1'b1;
            cycles(500);
        end
        cycles(SETTLE);
        stat_check("bounce_count", 32'h0);
        pop_check("bounce_no_event");

        // All four keys pressed together
        keys = 4'h0;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0000 | 32'(k));
        cycles(SETTLE);
        stat_check("all_keys_count", 32'h4);
        for (int k = 0; k < 4; k++) pop_check("all_keys_order");
        keys = 4'hf;
`ifdef BUTTON_RELEASE_EVT_EN
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0100 | 32'(k));
`endif
        cycles(SETTLE);
        drain("all_keys_release");
        stat_check("all_keys_drained", 32'h0);

        // Six presses without reads: last two overflow
        keys = 4'h0;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h8000_0000 | 32'(k));
        cycles(SETTLE);
        keys = 4'hf;
        cycles(SETTLE);
        keys = 4'b1100;
        cycles(SETTLE);
        stat_check("overflow_status", 32'h104);
        stat_check("overflow_cleared", 32'h004);
        for (int k = 0; k < 4; k++) pop_check("overflow_pop_order");
        keys = 4'hf;
`ifdef BUTTON_RELEASE_EVT_EN
        exp_q.push_back(32'h8000_0100);
        exp_q.push_back(32'h8000_0101);
`endif
        cycles(SETTLE);
        drain("overflow_release");
        stat_check("overflow_drained", 32'h0);

        // Held FIFO address pops only once
        keys = 4'b0011;
        exp_q.push_back(32'h8000_0002);
        exp_q.push_back(32'h8000_0003);
        cycles(SETTLE);
        @(negedge clk);
        busaddr = A_FIFO;
        #1 d = busdata;
        check("held_first_head", d, exp_q.pop_front());
        cycles(9);
        #1 check("held_head_after_10", busdata, exp_q[0]);
        busaddr = '0;
        stat_check("held_single_pop_count", 32'h1);
        pop_check("held_remaining_event");
        keys = 4'hf;
`ifdef BUTTON_RELEASE_EVT_EN
        exp_q.push_back(32'h8000_0102);
        exp_q.push_back(32'h8000_0103);
`endif
        cycles(SETTLE);
        drain("held_release");

        // Reset mid-debounce with an event queued: everything is discarded
        keys[3] = 1'b0;
        cycles(SETTLE);
        stat_check("pre_reset_queued", 32'h1);
        keys[0] = 1'b0;
        cycles(1500);
        keys = 4'hf;
        @(negedge clk);
        nrst = 1'b0;
        busaddr = A_FIFO;
        #1 check("in_reset_fifo_word", busdata, 32'h0);
        busaddr = A_STAT;
        #1 check("in_reset_status", busdata, 32'h0);
        busaddr = '0;
        cycles(3);
        nrst = 1'b1;
        cycles(SETTLE + MS);
        stat_check("post_reset_no_event", 32'h0);
        pop_check("post_reset_fifo_empty");

        // Key held through reset: press event exactly DBMSEC ms after release
        keys[1] = 1'b0;
        cycles(10);
        do_reset();
        cycles(2985);
        stat_check("held_reset_before_3ms", 32'h0);
        cycles(20);
        stat_check("held_reset_after_3ms", 32'h1);
        exp_q.push_back(32'h8000_0001);
        pop_check("held_reset_event");
        keys = 4'hf;
`ifdef BUTTON_RELEASE_EVT_EN
        exp_q.push_back(32'h8000_0101);
`endif
        cycles(SETTLE);
        drain("held_reset_release");
        stat_check("final_status", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
